// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_WIDTH = 32;
    localparam int unsigned FETCH_DEPTH = 2;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] instr;
        logic                   fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a registered head output and
// synchronous flush. DEPTH must be a power of two.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;
    fetch_entry_t  head_next;

    always_comb begin
        do_pop      = pop && (count != '0);
        do_push     = push && ((count < CW'(DEPTH)) || do_pop);
        rd_ptr_next = rd_ptr + PW'(do_pop);
        count_next  = count + CW'(do_push) - CW'(do_pop);
        // The pushed word becomes the new head when it lands in the slot
        // the read pointer is about to point at.
        if (count_next == '0) begin
            head_next = '0;
        end else if (do_push && (wr_ptr == rd_ptr_next)) begin
            head_next = push_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_next;
            wr_ptr     <= wr_ptr + PW'(do_push);
            count      <= count_next;
            head       <= head_next;
            head_valid <= (count_next != '0);
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: one outstanding instruction-memory read per accepted PC,
// results queued in a small FIFO toward decode; flush_i discards everything.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = FETCH_WIDTH,
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             pc_valid_i,
    output logic             pc_ready_o,
    input  logic             flush_i,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_pc_o,
    output logic [WIDTH-1:0] out_instr_o,
    output logic             out_fault_o
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [WIDTH-1:0] pending_pc;
    logic          pending_load;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          space;
    logic          push;
    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic          head_valid;
    logic          misaligned;

    always_comb begin
        occupancy  = {1'b0, count} + (CW+1)'(state != IDLE);
        space      = occupancy < (CW+1)'(DEPTH);
        misaligned = (pc_i[1:0] != 2'b00);
    end

    always_comb begin
        state_next   = state;
        mem_req_o    = 1'b0;
        pc_ready_o   = 1'b0;
        pending_load = 1'b0;
        push         = 1'b0;
        push_data    = '0;
        case (state)
            IDLE: begin
                // rst gates the combinational handshake so nothing is offered
                // to memory or the PC source while reset is held.
                if (rst && space && pc_valid_i && !flush_i) begin
                    if (misaligned) begin
                        pc_ready_o = 1'b1;
                        push       = 1'b1;
                        push_data  = '{pc: pc_i, instr: '0, fault: 1'b1};
                    end else begin
                        mem_req_o  = 1'b1;
                        pc_ready_o = mem_gnt_i;
                        if (mem_gnt_i) begin
                            state_next   = WAIT;
                            pending_load = 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_next = mem_rvalid_i ? IDLE : DROP;
                end else if (mem_rvalid_i) begin
                    push       = 1'b1;
                    push_data  = '{pc: pending_pc, instr: mem_rdata_i, fault: 1'b0};
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (mem_rvalid_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        mem_addr_o = mem_req_o ? pc_i : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pending_pc <= '0;
        end else begin
            state <= state_next;
            if (pending_load) begin
                pending_pc <= pc_i;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (out_ready_i && head_valid),
        .flush      (flush_i),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    always_comb begin
        out_valid_o = head_valid;
        out_pc_o    = head.pc;
        out_instr_o = head.instr;
        out_fault_o = head.fault;
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed self-checking bench for instr_fetch_buffer.
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pc_valid_i = 1'b0;
    logic        pc_ready_o;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_pc_o;
    logic [31:0] out_instr_o;
    logic        out_fault_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_buffer #(
        .WIDTH (32),
        .DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_pc_o     (out_pc_o),
        .out_instr_o  (out_instr_o),
        .out_fault_o  (out_fault_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pc_i = 32'h10; pc_valid_i = 1'b1; mem_gnt_i = 1'b1;
        tick(); tick();
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h want=0", mem_req_o); end
        total++; if (pc_ready_o !== 1'b0) begin bad++; $display("FAIL reset_pc_ready got=%0h want=0", pc_ready_o); end
        total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%0h want=0", mem_addr_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h want=0", out_valid_o); end
        total++; if ({out_pc_o, out_instr_o, out_fault_o} !== 65'h0) begin bad++; $display("FAIL reset_out_data got=%0h/%0h/%0h want=0/0/0", out_pc_o, out_instr_o, out_fault_o); end
        rst = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL release_mem_req got=%0h want=1", mem_req_o); end
        total++; if (mem_addr_o !== 32'h10) begin bad++; $display("FAIL release_mem_addr got=%0h want=10", mem_addr_o); end
        total++; if (pc_ready_o !== 1'b1) begin bad++; $display("FAIL release_pc_ready got=%0h want=1", pc_ready_o); end
        pc_valid_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
    endtask

    task automatic test_single_fetch();
        pc_i = 32'h10; pc_valid_i = 1'b1; mem_gnt_i = 1'b1;
        tick();
        pc_i = 32'h14; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00500093;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL wait_mem_req got=%0h want=0", mem_req_o); end
        total++; if (pc_ready_o !== 1'b0) begin bad++; $display("FAIL wait_pc_ready got=%0h want=0", pc_ready_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0h want=0", out_valid_o); end
        tick();
        pc_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h want=1", out_valid_o); end
        total++; if (out_pc_o !== 32'h10) begin bad++; $display("FAIL single_pc got=%0h want=10", out_pc_o); end
        total++; if (out_instr_o !== 32'h00500093) begin bad++; $display("FAIL single_instr got=%0h want=500093", out_instr_o); end
        total++; if (out_fault_o !== 1'b0) begin bad++; $display("FAIL single_fault got=%0h want=0", out_fault_o); end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_drained got=%0h want=0", out_valid_o); end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        pc_i = 32'h0; pc_valid_i = 1'b1; mem_gnt_i = 1'b1;
        tick();
        pc_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11111111;
        tick();
        mem_rvalid_i = 1'b0; pc_i = 32'h4; pc_valid_i = 1'b1; mem_gnt_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL bp_second_req got=%0h want=1", mem_req_o); end
        tick();
        pc_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h22222222;
        tick();
        mem_rvalid_i = 1'b0; pc_i = 32'h8; pc_valid_i = 1'b1; mem_gnt_i = 1'b1;
        #1;
        total++; if (pc_ready_o !== 1'b0) begin bad++; $display("FAIL bp_full_pc_ready got=%0h want=0", pc_ready_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL bp_full_mem_req got=%0h want=0", mem_req_o); end
        total++; if (out_pc_o !== 32'h0) begin bad++; $display("FAIL bp_head_pc got=%0h want=0", out_pc_o); end
        tick();
        total++; if (pc_ready_o !== 1'b0) begin bad++; $display("FAIL bp_hold_pc_ready got=%0h want=0", pc_ready_o); end
        out_ready_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle_req got=%0h want=0", mem_req_o); end
        tick();
        out_ready_i = 1'b0;
        #1;
        total++; if (out_pc_o !== 32'h4) begin bad++; $display("FAIL bp_after_pop_pc got=%0h want=4", out_pc_o); end
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL bp_resume_req got=%0h want=1", mem_req_o); end
        total++; if (mem_addr_o !== 32'h8) begin bad++; $display("FAIL bp_resume_addr got=%0h want=8", mem_addr_o); end
        total++; if (pc_ready_o !== 1'b1) begin bad++; $display("FAIL bp_resume_ready got=%0h want=1", pc_ready_o); end
        tick();
        pc_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h33333333;
        tick();
        mem_rvalid_i = 1'b0; out_ready_i = 1'b1;
        #1;
        total++; if (out_instr_o !== 32'h22222222) begin bad++; $display("FAIL bp_drain0_instr got=%0h want=22222222", out_instr_o); end
        tick();
        total++; if (out_pc_o !== 32'h8) begin bad++; $display("FAIL bp_drain1_pc got=%0h want=8", out_pc_o); end
        total++; if (out_instr_o !== 32'h33333333) begin bad++; $display("FAIL bp_drain1_instr got=%0h want=33333333", out_instr_o); end
        tick();
        out_ready_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0h want=0", out_valid_o); end
    endtask

    task automatic test_flush_wait();
        pc_i = 32'h20; pc_valid_i = 1'b1; mem_gnt_i = 1'b1;
        tick();
        pc_valid_i = 1'b0; mem_gnt_i = 1'b0; flush_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL fw_flush_req got=%0h want=0", mem_req_o); end
        tick();
        flush_i = 1'b0; pc_i = 32'h40; pc_valid_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL fw_drop_req got=%0h want=0", mem_req_o); end
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL fw_drop_rvalid_req got=%0h want=0", mem_req_o); end
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL fw_no_push got=%0h want=0", out_valid_o); end
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL fw_idle_req got=%0h want=1", mem_req_o); end
        total++; if (mem_addr_o !== 32'h40) begin bad++; $display("FAIL fw_idle_addr got=%0h want=40", mem_addr_o); end
        total++; if (pc_ready_o !== 1'b0) begin bad++; $display("FAIL fw_nognt_ready got=%0h want=0", pc_ready_o); end
        mem_gnt_i = 1'b1;
        tick();
        pc_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00A00113;
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL fw_refetch_valid got=%0h want=1", out_valid_o); end
        total++; if (out_pc_o !== 32'h40) begin bad++; $display("FAIL fw_refetch_pc got=%0h want=40", out_pc_o); end
        total++; if (out_instr_o !== 32'h00A00113) begin bad++; $display("FAIL fw_refetch_instr got=%0h want=a00113", out_instr_o); end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_flush_rvalid();
        pc_i = 32'h0; pc_valid_i = 1'b1; mem_gnt_i = 1'b1;
        tick();
        pc_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000005;
        tick();
        mem_rvalid_i = 1'b0; pc_i = 32'h4; pc_valid_i = 1'b1; mem_gnt_i = 1'b1;
        tick();
        pc_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000066; flush_i = 1'b1;
        #1;
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL fr_before_valid got=%0h want=1", out_valid_o); end
        tick();
        flush_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL fr_after_valid got=%0h want=0", out_valid_o); end
        pc_i = 32'h8; pc_valid_i = 1'b1; flush_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL fr_flush_idle_req got=%0h want=0", mem_req_o); end
        total++; if (pc_ready_o !== 1'b0) begin bad++; $display("FAIL fr_flush_idle_ready got=%0h want=0", pc_ready_o); end
        flush_i = 1'b0;
        #1;
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL fr_idle_req got=%0h want=1", mem_req_o); end
        pc_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_misaligned();
        pc_i = 32'h22; pc_valid_i = 1'b1; mem_gnt_i = 1'b0;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL mis_mem_req got=%0h want=0", mem_req_o); end
        total++; if (pc_ready_o !== 1'b1) begin bad++; $display("FAIL mis_pc_ready got=%0h want=1", pc_ready_o); end
        tick();
        pc_valid_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL mis_valid got=%0h want=1", out_valid_o); end
        total++; if (out_fault_o !== 1'b1) begin bad++; $display("FAIL mis_fault got=%0h want=1", out_fault_o); end
        total++; if (out_instr_o !== 32'h0) begin bad++; $display("FAIL mis_instr got=%0h want=0", out_instr_o); end
        total++; if (out_pc_o !== 32'h22) begin bad++; $display("FAIL mis_pc got=%0h want=22", out_pc_o); end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL mis_drained got=%0h want=0", out_valid_o); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_flush_wait();
        test_flush_rvalid();
        test_misaligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
